// File: rtl/adc_spi_reader.sv
// adc_spi_reader: CNV / BUSY / SCK sequencer for an LTC2389-class SAR ADC that
// delivers each conversion on a valid/ready stream with sticky status flags.
module adc_spi_reader #(
  parameter int DATA_W       = 24,
  parameter int SAMPLE_DIV   = 2083,
  parameter int SCK_HALF     = 13,
  parameter int CNV_HIGH     = 4,
  parameter int BUSY_TIMEOUT = 200,
  parameter int SIGN_EXT     = 0
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_busy,
  input  logic        i_sdo,
  output logic        o_cnv,
  output logic        o_sck,
  output logic        o_rdl_sdi,
  output logic        o_chain,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_overrun,
  output logic        o_tick_miss,
  output logic        o_timeout,
  input  logic        i_clr_status
);
  localparam int PW = $clog2(SAMPLE_DIV + 1);
  localparam int FW = $clog2(((BUSY_TIMEOUT > CNV_HIGH) ? BUSY_TIMEOUT : CNV_HIGH) + 1);
  localparam int HW = $clog2(SCK_HALF + 1);
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT, SHIFT, OUT} state_t;
  state_t state, state_next;

  logic              busy_meta, busy_s, busy_seen;
  logic [PW-1:0]     per_cnt;
  logic [FW-1:0]     frm_cnt;
  logic [HW-1:0]     half_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              tick, half_end, cnv_next, sck_next, capture, load, timeout_evt;

  // Widen the raw conversion result to the 32-bit stream word.
  function automatic logic [31:0] extend(input logic [DATA_W-1:0] raw);
    logic signed [DATA_W-1:0] sraw;
    sraw = raw;
    if (SIGN_EXT != 0) extend = 32'(sraw);
    else               extend = 32'(raw);
  endfunction

  assign o_rdl_sdi = 1'b0;
  assign o_chain   = 1'b0;
  assign tick      = i_enable && (per_cnt == PW'(SAMPLE_DIV - 1));
  assign half_end  = (half_cnt == HW'(SCK_HALF - 1));

  always_comb begin
    state_next  = state;
    cnv_next    = 1'b0;
    sck_next    = 1'b0;
    capture     = 1'b0;
    load        = 1'b0;
    timeout_evt = 1'b0;
    unique case (state)
      IDLE: if (tick) begin
        state_next = CONV;
        cnv_next   = 1'b1;
      end
      CONV: if (frm_cnt == FW'(CNV_HIGH - 1)) state_next = WAIT;
            else cnv_next = 1'b1;
      // BUSY must have been seen high this frame so a slow BUSY rise is not mistaken for completion
      WAIT: if (busy_seen && !busy_s) state_next = SHIFT;
            else if (frm_cnt >= FW'(BUSY_TIMEOUT - 1)) begin
              state_next  = IDLE;
              timeout_evt = 1'b1;
            end
      // SDO is captured on the same edge that raises SCK, so bit 0 of each period is the MSB first
      SHIFT: if (!o_sck) begin
               sck_next = half_end;
               capture  = half_end;
             end else if (!half_end) sck_next = 1'b1;
             else if (bit_cnt == BW'(DATA_W - 1)) state_next = OUT;
      OUT: begin
        state_next = IDLE;
        load       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      busy_meta   <= 1'b0;
      busy_s      <= 1'b0;
      busy_seen   <= 1'b0;
      per_cnt     <= '0;
      frm_cnt     <= '0;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_cnv       <= 1'b0;
      o_sck       <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_tick_miss <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      busy_meta <= i_busy;
      busy_s    <= busy_meta;
      per_cnt   <= (!i_enable || tick) ? '0 : per_cnt + PW'(1);
      frm_cnt   <= (state == CONV || state == WAIT) ? frm_cnt + FW'(1) : '0;
      busy_seen <= (state == IDLE) ? 1'b0 : (busy_seen || busy_s);
      half_cnt  <= (state == SHIFT && !half_end) ? half_cnt + HW'(1) : '0;
      if (state != SHIFT)        bit_cnt <= '0;
      else if (o_sck && half_end) bit_cnt <= bit_cnt + BW'(1);
      if (capture) shreg <= {shreg[DATA_W-2:0], i_sdo};
      o_cnv <= cnv_next;
      o_sck <= sck_next;
      if (load) begin
        o_data  <= extend(shreg);
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      // A set event on the same edge as a clear keeps the flag set
      o_overrun   <= (load && o_valid && !i_ready) || (o_overrun && !i_clr_status);
      o_tick_miss <= (tick && state != IDLE) || (o_tick_miss && !i_clr_status);
      o_timeout   <= timeout_evt || (o_timeout && !i_clr_status);
    end
  end
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: two readers (sign-extended 200-cycle period, zero-extended
// 100-cycle period) against a behavioural ADC, with a queue scoreboard on the stream.
module tb_adc_spi_reader;
  localparam int DW       = 24;
  localparam int PERIOD_A = 200;
  localparam int PERIOD_B = 100;
  localparam int SCK_H    = 2;
  localparam int CNV_H    = 3;
  localparam int BUSY_TO  = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  rst_n, en, ready_fix, rand_ready, rand_busy, hang, clr;
  logic        end_chk;
  int          busy_len [2];
  int          force_idx [2];
  logic [23:0] force_word [2];

  logic [1:0]  cnv_w, sck_w, valid_w, ovr_w, miss_w, to_w;
  logic [31:0] data_w [2];
  int          nload_w [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference extension: interpret the word as a two's-complement number when signed.
  function automatic logic [31:0] ref_ext(input logic [23:0] w, input bit sign);
    longint v;
    v = longint'(w);
    if (sign && w >= 24'h800000) v = v - 64'sd16777216;
    return 32'(v);
  endfunction

  for (genvar G = 0; G < 2; G++) begin : g_ch
    logic        busy = 1'b0, sdo = 1'b0, ready_r = 1'b1;
    logic        ready, rdl, chain;
    logic [23:0] word = '0;
    int          rises = 0, busy_cnt = 0, cnv_len = 0, last_rise = -1, nload = 0, frames = 0;
    logic        cnv_prev = 1'b0, sck_prev = 1'b0, prev_valid = 1'b0, done = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_q [$];

    assign ready      = rand_ready[G] ? ready_r : ready_fix[G];
    assign nload_w[G] = nload;

    adc_spi_reader #(
      .DATA_W(DW), .SAMPLE_DIV((G == 0) ? PERIOD_A : PERIOD_B), .SCK_HALF(SCK_H),
      .CNV_HIGH(CNV_H), .BUSY_TIMEOUT(BUSY_TO), .SIGN_EXT((G == 0) ? 1 : 0)
    ) dut (
      .clk(clk), .i_reset_n(rst_n[G]), .i_enable(en[G]), .i_busy(busy), .i_sdo(sdo),
      .o_cnv(cnv_w[G]), .o_sck(sck_w[G]), .o_rdl_sdi(rdl), .o_chain(chain),
      .o_data(data_w[G]), .o_valid(valid_w[G]), .i_ready(ready),
      .o_overrun(ovr_w[G]), .o_tick_miss(miss_w[G]), .o_timeout(to_w[G]),
      .i_clr_status(clr[G])
    );

    // ADC model plus stream monitor, evaluated away from the active edge
    always @(negedge clk) begin
      bit rise;
      if (rand_ready[G]) ready_r = 1'($urandom_range(0, 1));
      if (!rst_n[G]) begin
        exp_q.delete();
        busy = 1'b0; sdo = 1'b0; rises = 0; busy_cnt = 0; cnv_len = 0; last_rise = -1;
        cnv_prev = 1'b0; sck_prev = 1'b0; prev_valid = 1'b0; prev_data = '0;
      end else begin
        if (!en[G]) last_rise = -1;
        rise = cnv_w[G] && !cnv_prev;
        if (rise) begin
          if (last_rise >= 0)
            check("cnv_period", cyc - last_rise, (G == 0) ? PERIOD_A : 2 * PERIOD_B);
          last_rise = cyc;
          word = (frames == force_idx[G]) ? force_word[G] : 24'($urandom);
          frames++;
          rises = 0; busy = 1'b1; cnv_len = 1;
          busy_cnt = rand_busy[G] ? int'($urandom_range(5, 40)) : busy_len[G];
          if (!hang[G]) exp_q.push_back(ref_ext(word, G == 0));
        end else begin
          if (cnv_w[G]) cnv_len++;
          else if (cnv_prev) check("cnv_high_cycles", cnv_len, CNV_H);
          if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0 && !hang[G]) busy = 1'b0;
          end
        end
        if (sck_w[G] && !sck_prev) rises++;
        sdo = (rises < DW) ? word[DW-1-rises] : 1'b0;
        if (valid_w[G] && (!prev_valid || data_w[G] != prev_data)) begin
          nload++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_sample: got 0x%0h, expected no sample", data_w[G]);
          end else begin
            check("sample_data", data_w[G], exp_q.pop_front());
          end
          check("sck_rises_per_frame", rises, DW);
          check("rdl_chain_tied_low", {rdl, chain}, 0);
        end
        prev_valid = valid_w[G]; prev_data = data_w[G];
        cnv_prev = cnv_w[G]; sck_prev = sck_w[G];
      end
      if (end_chk && !done) begin
        done = 1'b1;
        check("scoreboard_drained", exp_q.size(), 0);
      end
    end
  end

  task automatic wait_loads(input int g, input int n, input int budget, input string what);
    int target, k;
    target = nload_w[g] + n;
    k = 0;
    while (nload_w[g] < target && k < budget) begin @(negedge clk); k++; end
    check(what, nload_w[g] >= target, 1);
  endtask

  task automatic wait_cnv(input int g, input int budget, output int t);
    int k;
    logic p;
    k = 0;
    do begin p = cnv_w[g]; @(negedge clk); k++; end
    while (!(cnv_w[g] && !p) && k < budget);
    check("cnv_rise_seen", k < budget, 1);
    t = cyc;
  endtask

  task automatic pulse_clr(input int g);
    clr[g] = 1'b1;
    @(negedge clk);
    clr[g] = 1'b0;
  endtask

  initial begin
    int t0, t1, k, cnt;
    logic sp;
    rst_n = '0; en = '0; ready_fix = 2'b11; rand_ready = '0; rand_busy = '0;
    hang = '0; clr = '0; end_chk = 1'b0;
    busy_len = '{20, 20}; force_idx = '{0, 0}; force_word = '{24'h800001, 24'hA5A5A5};
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset_ctrl_outputs", {cnv_w[g], sck_w[g], valid_w[g]}, 0);
      check("reset_flags", {ovr_w[g], miss_w[g], to_w[g]}, 0);
      check("reset_data", data_w[g], 0);
    end
    rst_n = 2'b11; en = 2'b11;
    wait_loads(0, 1, 400, "first_sample_a");
    wait_loads(1, 1, 400, "next_sample_b");
    check("tick_miss_long_frame", miss_w[1], 1);
    check("tick_miss_short_frame", miss_w[0], 0);

    rand_busy = 2'b11; rand_ready = 2'b11;
    wait_loads(0, 6, 1600, "random_samples_a");
    rand_busy = '0; rand_ready = '0;

    pulse_clr(0);
    check("overrun_cleared_before", ovr_w[0], 0);
    ready_fix[0] = 1'b0;
    wait_loads(0, 2, 600, "overrun_samples");
    check("overrun_valid_held", valid_w[0], 1);
    check("overrun_flag", ovr_w[0], 1);
    pulse_clr(0);
    check("overrun_clear", ovr_w[0], 0);
    check("valid_kept_after_clear", valid_w[0], 1);
    ready_fix[0] = 1'b1;
    @(negedge clk);
    check("valid_clears_on_accept", valid_w[0], 0);

    hang[0] = 1'b1;
    wait_cnv(0, 400, t0);
    cnt = 0; k = 0; sp = sck_w[0];
    while (!to_w[0] && k < 100) begin
      @(negedge clk);
      if (sck_w[0] && !sp) cnt++;
      sp = sck_w[0];
      k++;
    end
    check("timeout_latency", cyc - t0, BUSY_TO);
    check("timeout_no_sck", cnt, 0);
    hang[0] = 1'b0;
    wait_cnv(0, 250, t1);
    check("timeout_retry_period", t1 - t0, PERIOD_A);
    check("timeout_flag_sticky", to_w[0], 1);
    pulse_clr(0);
    check("timeout_clear", to_w[0], 0);
    wait_loads(0, 1, 300, "retry_sample");

    wait_cnv(0, 250, t0);
    repeat (30) @(negedge clk);
    en[0] = 1'b0; ready_fix[0] = 1'b0;
    wait_loads(0, 1, 300, "frame_completes_after_disable");
    cnt = 0; sp = cnv_w[0];
    repeat (450) begin
      @(negedge clk);
      if (cnv_w[0] && !sp) cnt++;
      sp = cnv_w[0];
    end
    check("no_cnv_while_disabled", cnt, 0);
    check("valid_held_before_reset", valid_w[0], 1);
    en[0] = 1'b1;

    wait_cnv(0, 400, t0);
    cnt = 0; k = 0; sp = sck_w[0];
    while (cnt < 10 && k < 400) begin
      @(negedge clk);
      if (sck_w[0] && !sp) cnt++;
      sp = sck_w[0];
      k++;
    end
    check("tenth_sck_rise_seen", cnt, 10);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midshift_reset_ctrl", {sck_w[0], cnv_w[0], valid_w[0]}, 0);
    check("midshift_reset_flags", {ovr_w[0], miss_w[0], to_w[0]}, 0);
    check("midshift_reset_data", data_w[0], 0);
    rst_n[0] = 1'b1; ready_fix[0] = 1'b1;
    wait_loads(0, 1, 500, "fresh_sample_after_reset");

    en = '0;
    repeat (400) @(negedge clk);
    end_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
